// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone burst traffic master.
// States, cycle-type codes and default widths live here.
package wb_master_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int DW_DEF      = 32;
    localparam int AW_DEF      = 26;
    localparam int LEN_W_DEF   = 8;
    localparam int ERR_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/wb_rd_checker.sv
// Read-data checker: compares acked read beats with the expected pattern
// and keeps a saturating mismatch count that only reset clears.
module wb_rd_checker #(
    parameter int dw    = 32,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk,
    input  logic [dw-1:0]    dat,
    input  logic [dw-1:0]    exp_dat,
    output logic [ERR_W-1:0] err_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (chk && (dat != exp_dat) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone incrementing-burst traffic master with pattern write/check.
// Optional watchdog abort: define WB_BURST_MASTER_TIMEOUT_EN.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int ERR_W       = ERR_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [dw-1:0]     cmd_seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [AW-1:0]     wb_addr_o,
    output logic [dw-1:0]     wb_dat_o,
    output logic [dw/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [dw-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              timeout
);

    state_t            state;
    logic [LEN_W-1:0]  k;
    logic [LEN_W-1:0]  last_idx;
    logic [dw-1:0]     pat;
    logic              ack;
    logic              last;
    logic              abort;

    assign ack       = wb_ack_i && wb_stb_o;
    assign last      = (k == last_idx);
    assign cmd_ready = (state == IDLE) && sdr_init_done;
    assign busy      = (state == BURST);
    assign wb_sel_o  = '1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_cti_o  <= CTI_CLASSIC;
            k         <= '0;
            last_idx  <= '0;
            pat       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= BURST;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= cmd_we;
                        wb_addr_o <= cmd_addr;
                        k         <= '0;
                        // zero-length commands run as a single beat
                        last_idx  <= (cmd_len == '0) ? '0 : cmd_len - 1'b1;
                        pat       <= cmd_seed;
                        wb_dat_o  <= cmd_we ? cmd_seed : '0;
                        wb_cti_o  <= (cmd_len <= LEN_W'(1)) ? CTI_EOB
                                                             : CTI_INCR;
                    end
                end
                BURST: begin
                    if ((ack && last) || abort) begin
                        state    <= IDLE;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_dat_o <= '0;
                        wb_cti_o <= CTI_CLASSIC;
                        done     <= 1'b1;
                    end else if (ack) begin
                        k         <= k + 1'b1;
                        wb_addr_o <= wb_addr_o + AW'(dw / 8);
                        pat       <= pat + 1'b1;
                        wb_dat_o  <= wb_we_o ? pat + 1'b1 : '0;
                        wb_cti_o  <= (k + 1'b1 == last_idx) ? CTI_EOB
                                                             : CTI_INCR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_rd_checker #(
        .dw    (dw),
        .ERR_W (ERR_W)
    ) u_chk (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .chk     (ack && !wb_we_o),
        .dat     (wb_dat_i),
        .exp_dat (pat),
        .err_cnt (err_cnt)
    );

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] wd_cnt;
    logic          to_r;

    // the cycle that would bring the count to the limit aborts instead
    assign abort   = (state == BURST) && !ack
                     && (wd_cnt == TW'(TIMEOUT_CYC - 1));
    assign timeout = to_r;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt <= '0;
            to_r   <= 1'b0;
        end else begin
            if ((state != BURST) || ack || abort) wd_cnt <= '0;
            else                                  wd_cnt <= wd_cnt + 1'b1;
            if (abort) to_r <= 1'b1;
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: scoreboarded bursts,
// wait states, read mismatches, address wrap and mid-burst reset.
module tb_wb_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [25:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_seed = '0;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;

    logic        cmd_ready, cyc, stb, we, busy, done, timeout;
    logic [25:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [15:0] err_cnt;

    typedef struct {
        logic [25:0] addr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [31:0] rdat;
    } beat_t;

    beat_t sb[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_err = 0;
    logic exp_to = 1'b0;

    always #5 clk = ~clk;

    wb_burst_master #(.TIMEOUT_CYC(16)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .sdr_init_done (init),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_seed      (cmd_seed),
        .wb_cyc_o      (cyc),
        .wb_stb_o      (stb),
        .wb_we_o       (we),
        .wb_addr_o     (addr),
        .wb_dat_o      (dat),
        .wb_sel_o      (sel),
        .wb_cti_o      (cti),
        .wb_ack_i      (ack),
        .wb_dat_i      (rdat),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt),
        .timeout       (timeout)
    );

    task automatic test_reset();
        rst = 1'b1; init = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_addr = 26'h40; cmd_len = 8'd1; cmd_seed = 32'h55;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({cyc, stb, we, busy, done, timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_ctrl: got %b expected 000000",
                     {cyc, stb, we, busy, done, timeout});
        end
        n_chk++;
        if ({addr, dat, cti} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: addr %h dat %h cti %b expected 0", addr, dat, cti);
        end
        n_chk++;
        if (sel !== 4'hF) begin
            n_fail++; $display("FAIL rst_sel: got %h expected f", sel);
        end
        n_chk++;
        if (err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rst_err: got %0d expected 0", err_cnt);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if ({cmd_ready, cyc} !== 2'b00) begin
                n_fail++;
                $display("FAIL init_gate: ready/cyc %b expected 00", {cmd_ready, cyc});
            end
        end
        init = 1'b1;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL init_ready: got %b expected 1", cmd_ready);
        end
        @(negedge clk);
        n_chk++;
        if ({cyc, stb, addr, dat, cti} !== {2'b11, 26'h40, 32'h55, 3'b111}) begin
            n_fail++;
            $display("FAIL init_accept: cyc %b stb %b addr %h dat %h cti %b",
                     cyc, stb, addr, dat, cti);
        end
        cmd_valid = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_chk++;
        if ({done, cyc} !== 2'b10) begin
            n_fail++; $display("FAIL init_done: done/cyc %b expected 10", {done, cyc});
        end
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL init_pulse: done %b expected 0", done);
        end
    endtask

    task automatic run_burst(input logic we_i, input logic [25:0] a,
                             input logic [7:0] len, input logic [31:0] seed,
                             input int bad_k, input int wait_k,
                             input int wait_n, input bit drop_init);
        int    n = (len == 8'd0) ? 1 : int'(len);
        int    beats = 0;
        int    waits = 0;
        int    budget = 0;
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = a + 26'(4 * i);
            e.dat  = we_i ? seed + 32'(i) : 32'h0;
            e.cti  = (i == n - 1) ? 3'b111 : 3'b010;
            e.rdat = (i == bad_k) ? 32'hFF : seed + 32'(i);
            if (!we_i && e.rdat != seed + 32'(i)) exp_err++;
            sb.push_back(e);
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we_i;
        cmd_addr = a; cmd_len = len; cmd_seed = seed;
        #1;
        while (!cmd_ready && budget < 50) begin
            @(negedge clk); budget++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        budget = 0;
        while (beats < n && budget < 200) begin
            budget++;
            n_chk++;
            if ({cyc, stb, busy, we} !== {3'b111, we_i}) begin
                n_fail++;
                $display("FAIL beat_ctrl: cyc/stb/busy/we %b expected %b",
                         {cyc, stb, busy, we}, {3'b111, we_i});
            end
            if (beats == wait_k && waits < wait_n) begin
                ack = 1'b0; waits++;
            end else begin
                e = sb.pop_front();
                n_chk++;
                if ({addr, dat, cti} !== {e.addr, e.dat, e.cti}) begin
                    n_fail++;
                    $display("FAIL beat%0d: addr %h dat %h cti %b expected %h %h %b",
                             beats, addr, dat, cti, e.addr, e.dat, e.cti);
                end
                ack = 1'b1; rdat = e.rdat; beats++;
                if (drop_init) init = 1'b0;
            end
            @(negedge clk);
        end
        ack = 1'b0; rdat = '0;
        n_chk++;
        if (beats != n) begin
            n_fail++; $display("FAIL burst_budget: beats %0d expected %0d", beats, n);
        end
        n_chk++;
        if ({done, cyc, stb, we, busy, timeout} !== {5'b10000, exp_to}) begin
            n_fail++;
            $display("FAIL burst_end: done/cyc/stb/we/busy/to %b expected %b",
                     {done, cyc, stb, we, busy, timeout}, {5'b10000, exp_to});
        end
        n_chk++;
        if (cmd_ready !== init) begin
            n_fail++; $display("FAIL done_ready: got %b expected %b", cmd_ready, init);
        end
        n_chk++;
        if (err_cnt !== 16'(exp_err)) begin
            n_fail++; $display("FAIL err_cnt: got %0d expected %0d", err_cnt, exp_err);
        end
        init = 1'b1;
        @(negedge clk);
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse: got %b expected 0", done);
        end
    endtask

    task automatic test_write();
        run_burst(1'b1, 26'h100, 8'd4, 32'hA0, -1, -1, 0, 1'b0);
    endtask

    task automatic test_read_mismatch();
        run_burst(1'b0, 26'h100, 8'd4, 32'hA0, 1, 2, 2, 1'b0);
    endtask

    task automatic test_len_edges();
        run_burst(1'b1, 26'h3FFFFFC, 8'd0, 32'h10, -1, -1, 0, 1'b0);
        run_burst(1'b0, 26'h3FFFFFC, 8'd1, 32'h20, -1, -1, 0, 1'b0);
        run_burst(1'b1, 26'h3FFFFFC, 8'd2, 32'hFFFFFFFF, -1, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst(1'b0, 26'h20, 8'd3, 32'h7, -1, -1, 0, 1'b1);
        run_burst(1'b1, 26'h40, 8'd5, 32'h9, -1, 3, 1, 1'b0);
    endtask

    task automatic test_stray_ack();
        ack = 1'b1; rdat = 32'hDEAD;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if ({cyc, done, busy} !== 3'b000 || err_cnt !== 16'(exp_err)) begin
                n_fail++;
                $display("FAIL stray_ack: cyc/done/busy %b err %0d expected 000 %0d",
                         {cyc, done, busy}, err_cnt, exp_err);
            end
        end
        ack = 1'b0; rdat = '0;
    endtask

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1;
        cmd_addr = 26'h300; cmd_len = 8'd4; cmd_seed = 32'h1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc && cnt < 100) begin
            cnt++; @(negedge clk);
        end
        n_chk++;
        if (cnt != 16 || {done, timeout} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout: cycles %0d done/to %b expected 16 11",
                     cnt, {done, timeout});
        end
        exp_to = 1'b1;
        run_burst(1'b1, 26'h0, 8'd2, 32'h3, -1, -1, 0, 1'b0);
    endtask
`else
    task automatic test_timeout();
        run_burst(1'b1, 26'h200, 8'd2, 32'h1234, -1, 0, 40, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_burst();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0;
        cmd_addr = 26'h80; cmd_len = 8'd8; cmd_seed = 32'h33;
        @(negedge clk);
        cmd_valid = 1'b0;
        ack = 1'b1; rdat = 32'h33;
        @(negedge clk);
        rdat = 32'h34;
        @(negedge clk);
        ack = 1'b0; rdat = '0;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({cyc, stb, busy, done} !== 4'b0000 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: cyc/stb/busy/done %b err %0d expected 0000 0",
                     {cyc, stb, busy, done}, err_cnt);
        end
        exp_err = 0; exp_to = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if ({done, cyc} !== 2'b00) begin
                n_fail++;
                $display("FAIL post_reset: done/cyc %b expected 00", {done, cyc});
            end
        end
        run_burst(1'b0, 26'h10, 8'd2, 32'h5, 0, -1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_mismatch();
        test_len_edges();
        test_back_to_back();
        test_stray_ack();
        test_timeout();
        test_reset_mid_burst();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL sb_drain: %0d beats left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Wishbone burst traffic master that drives the wb_* slave side of the SDRAM controller under test.
- Accepts one command at a time (address, beat count, direction, seed) and executes one incrementing Wishbone burst.
- Write beats carry a deterministic pattern. Read beats are checked against the same pattern, and mismatches are counted.
- Sits directly upstream of the SDRAM controller's Wishbone port in the test environment.

Parameters:
- dw, 32, Wishbone data width (8/16/32).
- AW, 26, Wishbone byte-address width.
- LEN_W, 8, width of the beat-count field.
- ERR_W, 16, width of the mismatch counter.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- sdr_init_done  in  1  SDRAM init complete; no command is accepted while low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start byte address.
- cmd_len  in  LEN_W  beat count; 0 is treated as 1.
- cmd_seed  in  dw  pattern seed.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_addr_o  out  AW  byte address.
- wb_dat_o  out  dw  write data.
- wb_sel_o  out  dw/8  byte enables; always all ones.
- wb_cti_o  out  3  cycle type.
- wb_ack_i  in  1  slave acknowledge.
- wb_dat_i  in  dw  read data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err_cnt  out  ERR_W  cumulative read mismatches, saturating.
- timeout  out  1  sticky watchdog flag; held 0 without the optional feature.

Behaviour:
- Reset (async assert, synchronous release of logic): all outputs 0, except wb_sel_o = all ones. State = IDLE; err_cnt = 0; timeout = 0.
- Reset asserted mid-burst drops wb_cyc_o/wb_stb_o immediately. No partial completion is reported.
- Command accept:
  - cmd_ready = (state == IDLE) && sdr_init_done.
  - A command is accepted on the edge where cmd_valid && cmd_ready. Fields are registered.
- Burst start: the next cycle enters BURST with:
  - wb_cyc_o = wb_stb_o = 1;
  - wb_we_o = cmd_we;
  - wb_addr_o = cmd_addr;
  - beat index k = 0;
  - busy = 1.
- Pattern: beat k data = cmd_seed + k, modulo 2^dw.
  - wb_dat_o presents this value for write bursts.
  - For read bursts wb_dat_o is 0.
- Beat advance: on each cycle with wb_ack_i && wb_stb_o:
  - k increments;
  - wb_addr_o advances by dw/8, wrapping modulo 2^AW;
  - wb_dat_o updates in the same edge.
  - cyc/stb stay asserted between beats; there are no idle strobes inside a burst.
- Cycle type:
  - wb_cti_o = 3'b010 while k < len-1;
  - wb_cti_o = 3'b111 on the last beat;
  - for len = 1, 3'b111 from the first cycle.
- Read check: on a read ack, if wb_dat_i != seed + k, err_cnt increments. It saturates at all ones and is never cleared except by reset.
- Last-beat ack:
  - cyc/stb/we drop on the next edge;
  - state returns to IDLE;
  - done pulses for exactly that one cycle;
  - busy clears.
  - cmd_ready may assert in the same cycle as done.
- Back-to-back commands are allowed. Minimum gap is one IDLE cycle between bursts.
- wb_ack_i while wb_cyc_o = 0 is ignored.
- sdr_init_done falling mid-burst has no effect. It only gates acceptance.

Optional Feature:
- Macro WB_BURST_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on every ack and on burst start, and increments each BURST cycle without an ack.
  - When it reaches TIMEOUT_CYC, the burst aborts: cyc/stb drop next edge, state returns to IDLE, done pulses, and timeout is set sticky until reset.
- When undefined:
  - No counter is built; timeout is tied to 0.
  - A burst waits for acks indefinitely.

Decomposition:
- Package wb_master_pkg holds:
  - state enum {IDLE, BURST};
  - CTI constants CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111;
  - default width localparams.
- Sub-module wb_rd_checker: compares wb_dat_i against the expected pattern on read acks and owns the saturating err_cnt.
- Sequencing, address and pattern generation stay in the top module.

Test Plan:
- Reset release with sdr_init_done = 0, cmd_valid = 1 -> cmd_ready stays 0 and no cyc. Raise init_done -> command accepted on the next edge.
- Write, addr 0x100, len 4, seed 0xA0, dw 32, slave acks every cycle -> four beats:
  - addresses 0x100/0x104/0x108/0x10C;
  - data 0xA0..0xA3;
  - cti 010, 010, 010, 111;
  - one done pulse.
- Read, len 4, seed 0xA0, slave returns 0xA0, 0xFF, 0xA2, 0xA3 with a 2-cycle wait state before beat 2 -> err_cnt = 1, stb held through the wait, done once.
- len 0 and len 1 at addr 0x3FFFFFC -> single beat with cti 111. A following len-2 burst from 0x3FFFFFC wraps its second address to 0x0000000.
- Assert wb_rst_i during beat 2 of an 8-beat burst -> cyc/stb/busy are 0 asynchronously, err_cnt = 0, no done pulse.
- With WB_BURST_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 16, slave never acks -> abort after 16 cycles, done pulse, timeout = 1 and stays 1 across later successful bursts.
